// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and helpers for the instruction-memory loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    // A load must cover at least one word and must fit in the memory.
    function automatic logic len_legal(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembler with byte index
module byte_packer
    import loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             byte_fire,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_full
);

    localparam int BPW   = bytes_per_word(WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] buf_q, buf_d;

    assign word_full = byte_fire && (idx_q == IDX_W'(BPW - 1));
    assign word      = buf_q;

    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        if (clr) begin
            idx_d = '0;
        end else if (byte_fire) begin
            for (int k = 0; k < BPW; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    buf_d[8*k +: 8] = byte_data;
                end
            end
            idx_d = word_full ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            buf_q <= '0;
        end else begin
            idx_q <= idx_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams bytes into instruction memory and holds the core in reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 20,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t     state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] widx_q;
    logic              err_q;

    logic             start_seen;
    logic             start_legal;
    logic             pk_clr;
    logic             pk_fire;
    logic             word_full;
    logic             last_word;
    logic [WIDTH-1:0] word;

    // start only matters while no load is in flight
    assign start_seen  = start && ((state_q == IDLE) || (state_q == DONE));
    assign start_legal = len_legal(32'(len), 32'(DEPTH));
    assign pk_clr      = start_seen && start_legal;
    assign pk_fire     = byte_valid && (state_q == RECV);
    assign last_word   = ({1'b0, widx_q} == (len_q - 1'b1));

    byte_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pk_clr),
        .byte_fire(pk_fire),
        .byte_data(byte_data),
        .word     (word),
        .word_full(word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (start_legal) begin
                            len_q   <= len;
                            widx_q  <= '0;
                            state_q <= RECV;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (word_full) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state_q <= DONE;
                    end else begin
                        widx_q  <= widx_q + 1'b1;
                        state_q <= RECV;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state_q == RECV);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = widx_q;
    assign mem_wdata  = word;
    assign core_rst   = (state_q != DONE);
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the single-cycle core. It accepts a byte stream over a valid/ready handshake and packs it little-endian into WIDTH-bit words. It writes those words into the instruction memory's write port and holds the core in reset (`core_rst`) until the programmed image is complete. It sits between the host/bench-side byte source and the `top` instruction memory; once `core_rst` drops, the core's PC starts fetching from word 0.

## Interface

Parameters:
- `WIDTH`, 32, instruction word width in bits; must be a multiple of 8.
- `DEPTH`, 20, instruction memory depth in words.
- `ADDR_W`, `$clog2(DEPTH)`, derived word-address width; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `len`  in  ADDR_W+1  number of words to load; captured on accepted `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  WIDTH  assembled word.
- `core_rst`  out  1  holds the core in reset; low only in DONE.
- `busy`  out  1  high in RECV and WRITE.
- `done`  out  1  level; high in DONE.
- `err`  out  1  one-cycle pulse when `start` carries an illegal `len`.

## Operation

- The state machine has four states: IDLE, RECV, WRITE, DONE.
- IDLE: `start` with 1 ≤ `len` ≤ DEPTH latches `len`, clears the word index and byte index, then goes to RECV. `start` with `len`=0 or `len`>DEPTH pulses `err` next cycle and stays in IDLE.
- RECV: `byte_ready`=1. On `byte_valid && byte_ready`, `byte_data` goes to bits [8*k+7:8*k] of the word buffer, where k is the byte index. Byte 0 is the LSB.
  - The byte index increments on each accepted byte.
  - Accepting byte WIDTH/8−1 moves the FSM to WRITE and wraps the byte index to 0.
- WRITE: `byte_ready`=0 and `mem_we`=1 for exactly one cycle, with `mem_addr` = word index and `mem_wdata` = buffer.
  - If word index = `len`−1, go to DONE.
  - Otherwise increment the word index and go to RECV.
- DONE: `core_rst`=0 and `done`=1. A legal `start` re-enters RECV, re-asserts `core_rst`, and overwrites memory from word 0. An illegal `start` pulses `err` and stays in DONE.
- `start` in RECV or WRITE is ignored, with no `err`.
- Bytes offered outside RECV are not consumed.
- Unwritten memory words beyond `len` keep their prior contents.

## Timing

- Reset values: state=IDLE, `core_rst`=1, `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are decoded from registers (state, buffer, indices). There is no combinational path from any input to any output.
- `start` accepted at edge N puts the FSM in RECV during cycle N+1, with `byte_ready` high in that cycle.
- Throughput: WIDTH/8 accept cycles plus 1 write cycle per word, so 5 cycles per word at WIDTH=32 with `byte_valid` held high.
- The last write cycle is followed by DONE, where `core_rst` falls on the next edge. Total with continuous valid is 1 + 5·`len` cycles from `start` to `core_rst`=0.
- Source stalls (`byte_valid`=0) hold all state in RECV.
- `rst` mid-load aborts immediately: state returns to IDLE and `core_rst`=1. A partial image remains in memory, and a new `start` is required.
- `err` is high for exactly one cycle, the cycle after the illegal `start`.

## Structure

- Shared package `loader_pkg` holds:
  - the `loader_state_t` enum (IDLE, RECV, WRITE, DONE);
  - the constant `BYTES_PER_WORD` = WIDTH/8 as a function of WIDTH;
  - a helper for the legal-`len` check.
- One sub-module, `byte_packer`: the byte index counter plus word buffer. Its inputs are `clk`, `rst`, `clr`, and `byte_fire`/`byte_data`. It outputs `word` and a `word_full` pulse on the last byte.
- The top `imem_loader` holds the FSM, the word index, `len` capture, and the memory-port drive.
- `top` instantiates `imem_loader` and muxes its write port into instruction memory; `core_rst` ORs with `rst` into the core.

## Test plan

- Reset: assert `rst` for 2 cycles → all outputs at their reset values and `core_rst`=1. Release → still IDLE, `byte_ready`=0.
- Single word: `start`, `len`=1, then bytes 0x13,0x00,0x00,0x00 back-to-back → one `mem_we` pulse with `mem_addr`=0 and `mem_wdata`=0x00000013. `done`=1 and `core_rst`=0 exactly 6 cycles after `start`.
- Full image with stalls: `len`=20, 80 bytes with `byte_valid` randomly deasserted → 20 writes at addresses 0..19 in order, each word equal to the little-endian packing of its 4 bytes, and no byte lost or duplicated.
- Illegal length: `start` with `len`=0, then with `len`=21 → `err` pulses one cycle each, state stays IDLE, and no `mem_we`.
- Reset mid-load: `len`=4, reset asserted after 7 accepted bytes → only word 0 written, outputs at reset values. A fresh `start` with `len`=1 reloads address 0 correctly.
- Reload from DONE: after a `len`=2 load, `start` with `len`=1 → `core_rst` goes high the next cycle, only address 0 is rewritten, and DONE is re-entered.
